// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, execute redirect and the decode-side output handshake.
// Width macros WORD_BITS / DWORD_BITS default to 32 / 64 when not supplied by the build.
`ifndef WORD_BITS
`define WORD_BITS 32
`endif
`ifndef DWORD_BITS
`define DWORD_BITS 64
`endif

// out_valid/out_ready: the head entry transfers on a rising edge where both are high.
// out_valid never depends on out_ready, and a redirect in the same cycle cancels the transfer.
interface fetch_stage_if;
    logic [`DWORD_BITS-1:0] imem_pc;
    logic [`WORD_BITS-1:0]  imem_instr;
    logic                   redirect_valid;
    logic [`DWORD_BITS-1:0] redirect_pc;
    logic                   out_valid;
    logic                   out_ready;
    logic [`WORD_BITS-1:0]  out_instr;
    logic [`DWORD_BITS-1:0] out_pc;
    logic                   out_misaligned;

    modport master (
        output imem_pc,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_misaligned
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_misaligned
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, 2-entry {pc, instr, misaligned} buffer toward decode, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect injects one flagged NOP and halts fetch.
`ifndef WORD_BITS
`define WORD_BITS 32
`endif
`ifndef DWORD_BITS
`define DWORD_BITS 64
`endif

module fetch_stage #(
    parameter logic [`DWORD_BITS-1:0] RESET_PC = 64'h0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus,
    output logic          o_dbg_halt
);

    localparam logic [`WORD_BITS-1:0] NOP = 32'h0000_0013;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [`DWORD_BITS-1:0]  r_pc;
    logic [1:0]              r_count;
    logic                    r_rd;
    logic                    r_wr;
    logic [`DWORD_BITS-1:0]  r_ent_pc    [2];
    logic [`WORD_BITS-1:0]   r_ent_instr [2];
    logic                    w_pop;
    logic                    w_push;
    logic                    w_redir_mis;
    logic [`DWORD_BITS-1:0]  w_redir_pc;

    assign w_pop  = (r_count != 2'd0) & bus.out_ready;
    assign w_push = (r_state == S_RUN) & ~bus.redirect_valid & ((r_count < 2'd2) | w_pop);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic [1:0] r_ent_mis;
    assign w_redir_mis        = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
    assign w_redir_pc         = bus.redirect_pc;
    assign bus.out_misaligned = r_ent_mis[r_rd];
`else
    // Without the check, the low target bits are simply dropped.
    assign w_redir_mis        = 1'b0;
    assign w_redir_pc         = {bus.redirect_pc[`DWORD_BITS-1:2], 2'b00};
    assign bus.out_misaligned = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_valid) begin
            w_state_nxt = w_redir_mis ? S_HALT : S_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_count <= 2'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_ent_pc[i]    <= '0;
                r_ent_instr[i] <= '0;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            r_ent_mis <= 2'b00;
`endif
        end else if (bus.redirect_valid) begin
            // Redirect wins over any push/pop this cycle.
            r_pc <= w_redir_pc;
            r_rd <= 1'b0;
            if (w_redir_mis) begin
                r_ent_pc[0]    <= bus.redirect_pc;
                r_ent_instr[0] <= NOP;
`ifdef FETCH_MISALIGN_CHECK_EN
                r_ent_mis[0]   <= 1'b1;
`endif
                r_count        <= 2'd1;
                r_wr           <= 1'b1;
            end else begin
                r_count <= 2'd0;
                r_wr    <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_ent_pc[r_wr]    <= r_pc;
                r_ent_instr[r_wr] <= bus.imem_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
                r_ent_mis[r_wr]   <= 1'b0;
`endif
                r_wr              <= ~r_wr;
                r_pc              <= r_pc + 64'd4;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.imem_pc   = r_pc;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_instr = r_ent_instr[r_rd];
    assign bus.out_pc    = r_ent_pc[r_rd];
    assign o_dbg_halt    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: word i at address 4i, scoreboarded decode-side pops, redirect/stall/reset cases.
// A second instance with RESET_PC near the top of the address space checks PC wraparound.
module tb_fetch_stage;

    logic clk;
    logic reset;
    logic dbg_halt;
    logic dbg2_halt;
    int   n_vec;
    int   n_err;

    logic [96:0] exp_q[$];
    logic [96:0] exp2_q[$];
    logic [96:0] mon_e;
    logic [96:0] mon2_e;

    fetch_stage_if bus ();
    fetch_stage_if bus2 ();

    fetch_stage #(.RESET_PC(64'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .o_dbg_halt (dbg_halt)
    );

    fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus2),
        .o_dbg_halt (dbg2_halt)
    );

    assign bus.imem_instr  = bus.imem_pc[33:2];
    assign bus2.imem_instr = bus2.imem_pc[33:2];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [96:0] mk(input logic [63:0] pc, input logic [31:0] ins, input logic mis);
        return {mis, ins, pc};
    endfunction

    task automatic sb_fill(input logic [63:0] start, input int n);
        logic [63:0] pc;
        exp_q.delete();
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk(pc, pc[33:2], 1'b0));
            pc = pc + 64'd4;
        end
    endtask

    task automatic sb2_fill(input logic [63:0] start, input int n);
        logic [63:0] pc;
        exp2_q.delete();
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp2_q.push_back(mk(pc, pc[33:2], 1'b0));
            pc = pc + 64'd4;
        end
    endtask

    // driver: inputs change just after the active edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // scoreboard: compare every accepted head against the expected stream
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_empty", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("pop_pc", bus.out_pc, mon_e[63:0]);
                check_eq("pop_instr", {32'h0, bus.out_instr}, {32'h0, mon_e[95:64]});
                check_eq("pop_mis", {63'h0, bus.out_misaligned}, {63'h0, mon_e[96]});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && bus2.out_valid && bus2.out_ready) begin
            if (exp2_q.size() == 0) begin
                check_eq("sb2_empty", 64'd1, 64'd0);
            end else begin
                mon2_e = exp2_q.pop_front();
                check_eq("wrap_pc", bus2.out_pc, mon2_e[63:0]);
                check_eq("wrap_instr", {32'h0, bus2.out_instr}, {32'h0, mon2_e[95:64]});
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.out_ready       = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 64'h0;
        bus2.out_ready      = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 64'h0;
        #3;
        check_eq("rst_imem_pc", bus.imem_pc, 64'h0);
        check_eq("rst_valid", {63'h0, bus.out_valid}, 64'h0);
        check_eq("rst_out_pc", bus.out_pc, 64'h0);
        check_eq("rst_out_instr", {32'h0, bus.out_instr}, 64'h0);
        check_eq("rst_mis", {63'h0, bus.out_misaligned}, 64'h0);
        check_eq("rst_halt", {63'h0, dbg_halt}, 64'h0);
        check_eq("rst2_imem_pc", bus2.imem_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        sb_fill(64'h0, 64);
        sb2_fill(64'hFFFF_FFFF_FFFF_FFF8, 200);
        tick();
        tick();
        reset = 1'b0;

        // streaming with ready held high
        tick();
        repeat (8) begin
            @(negedge clk);
            check_eq("stream_valid", {63'h0, bus.out_valid}, 64'h1);
            tick();
        end

        // restart at 0 with decode stalled: buffer fills, pc holds at 8
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0;
        bus.out_ready      = 1'b0;
        sb_fill(64'h0, 64);
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        repeat (4) tick();
        @(negedge clk);
        check_eq("stall_imem_pc", bus.imem_pc, 64'h8);
        check_eq("stall_head_pc", bus.out_pc, 64'h0);
        check_eq("stall_head_instr", {32'h0, bus.out_instr}, 64'h0);
        check_eq("stall_valid", {63'h0, bus.out_valid}, 64'h1);
        tick();
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_eq("drain_valid", {63'h0, bus.out_valid}, 64'h1);
            tick();
        end

        // redirect to 0x40 while full and ready high
        bus.out_ready = 1'b0;
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h40;
        bus.out_ready      = 1'b1;
        sb_fill(64'h40, 64);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("redir_valid", {63'h0, bus.out_valid}, 64'h0);
        check_eq("redir_imem_pc", bus.imem_pc, 64'h40);
        tick();
        repeat (4) begin
            @(negedge clk);
            check_eq("redir_stream_valid", {63'h0, bus.out_valid}, 64'h1);
            tick();
        end

        // misaligned redirect to 0x42
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h42;
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_q.delete();
        exp_q.push_back(mk(64'h42, 32'h0000_0013, 1'b1));
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("mis_valid", {63'h0, bus.out_valid}, 64'h1);
        check_eq("mis_flag", {63'h0, bus.out_misaligned}, 64'h1);
        check_eq("mis_halt", {63'h0, dbg_halt}, 64'h1);
        check_eq("mis_imem_pc", bus.imem_pc, 64'h42);
        tick();
        repeat (3) begin
            @(negedge clk);
            check_eq("halt_valid", {63'h0, bus.out_valid}, 64'h0);
            check_eq("halt_imem_pc", bus.imem_pc, 64'h42);
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h80;
        sb_fill(64'h80, 64);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("resume_halt", {63'h0, dbg_halt}, 64'h0);
        check_eq("resume_imem_pc", bus.imem_pc, 64'h80);
        tick();
`else
        sb_fill(64'h40, 64);
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("align_imem_pc", bus.imem_pc, 64'h40);
        check_eq("align_valid", {63'h0, bus.out_valid}, 64'h0);
        check_eq("align_halt", {63'h0, dbg_halt}, 64'h0);
        tick();
`endif
        repeat (3) begin
            @(negedge clk);
            check_eq("post_mis_valid", {63'h0, bus.out_valid}, 64'h1);
            tick();
        end

        // asynchronous reset mid-stream with the buffer full
        bus.out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("arst_imem_pc", bus.imem_pc, 64'h0);
        check_eq("arst_valid", {63'h0, bus.out_valid}, 64'h0);
        check_eq("arst_out_pc", bus.out_pc, 64'h0);
        check_eq("arst_out_instr", {32'h0, bus.out_instr}, 64'h0);
        check_eq("arst_mis", {63'h0, bus.out_misaligned}, 64'h0);
        check_eq("arst2_imem_pc", bus2.imem_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        check_eq("arst2_valid", {63'h0, bus2.out_valid}, 64'h0);
        sb_fill(64'h0, 64);
        sb2_fill(64'hFFFF_FFFF_FFFF_FFF8, 200);
        bus.out_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        repeat (4) begin
            @(negedge clk);
            check_eq("restart_valid", {63'h0, bus.out_valid}, 64'h1);
            tick();
        end

        #20;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
